alu_sequencer: RTL

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_pkg.sv | 32 +++
 rtl/alu_div_timer.sv | 36 +++
 rtl/alu_sequencer.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared function codes, FSM state encoding and op classification for the
// ALU sequencer and its divide timer.
package alu_pkg;

  localparam logic [5:0] FN_AND  = 6'd36;
  localparam logic [5:0] FN_OR   = 6'd37;
  localparam logic [5:0] FN_ADD  = 6'd32;
  localparam logic [5:0] FN_SUB  = 6'd34;
  localparam logic [5:0] FN_SLT  = 6'd42;
  localparam logic [5:0] FN_SRL  = 6'd2;
  localparam logic [5:0] FN_DIVU = 6'd27;
  localparam logic [5:0] FN_MFHI = 6'd16;
  localparam logic [5:0] FN_MFLO = 6'd18;
  localparam logic [5:0] FN_NOP  = 6'd0;

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    DIV_WAIT,
    RD_HI,
    RD_LO,
    RESP
  } state_e;

  function automatic logic is_supported(input logic [5:0] op);
    case (op)
      FN_AND, FN_OR, FN_ADD, FN_SUB, FN_SLT, FN_SRL, FN_DIVU: is_supported = 1'b1;
      default:                                                is_supported = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/alu_div_timer.sv
// Down-counter that holds the divide phase open for DIV_CYCLES cycles:
// load presets DIV_CYCLES-1, en decrements, done flags zero.
module alu_div_timer #(
  parameter int DIV_CYCLES = 32
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic en_i,
  output logic done_o
);

  localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = CW'(DIV_CYCLES - 1);
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/alu_sequencer.sv
// Sequences single operations through an external ALU: single-cycle ops,
// multi-cycle DIVU with MFHI/MFLO read-out, and rejection of unknown codes.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int DIV_CYCLES = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [5:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        req_ready,
  output logic [5:0]  alu_signal,
  output logic [31:0] alu_dataA,
  output logic [31:0] alu_dataB,
  input  logic [31:0] alu_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_lo,
  output logic [31:0] rsp_hi,
  output logic        rsp_err
);

  state_e      state_q, state_d;
  logic [5:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] hi_q, hi_d;
  logic        err_q, err_d;
  logic        div_load;
  logic        div_done;

  alu_div_timer #(
    .DIV_CYCLES(DIV_CYCLES)
  ) u_div_timer (
    .clk    (clk),
    .reset  (reset),
    .load_i (div_load),
    .en_i   (state_q == DIV_WAIT),
    .done_o (div_done)
  );

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    lo_d       = lo_q;
    hi_d       = hi_q;
    err_d      = err_q;
    div_load   = 1'b0;
    alu_signal = FN_NOP;
    alu_dataA  = '0;
    alu_dataB  = '0;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d  = req_op;
          a_d   = req_a;
          b_d   = req_b;
          err_d = !is_supported(req_op);
          lo_d  = '0;
          hi_d  = '0;
          if (req_op == FN_DIVU) begin
            div_load = 1'b1;
            state_d  = DIV_WAIT;
          end else begin
            state_d  = EXEC;
          end
        end
      end
      EXEC: begin
        // Unsupported codes pass through EXEC only to keep the N+1 response timing.
        if (!err_q) begin
          alu_signal = op_q;
          alu_dataA  = a_q;
          alu_dataB  = b_q;
          lo_d       = alu_out;
        end else begin
          lo_d       = '0;
        end
        hi_d    = '0;
        state_d = RESP;
      end
      DIV_WAIT: begin
        alu_signal = FN_DIVU;
        alu_dataA  = a_q;
        alu_dataB  = b_q;
        if (div_done) begin
          state_d = RD_HI;
        end
      end
      RD_HI: begin
        alu_signal = FN_MFHI;
        alu_dataA  = a_q;
        alu_dataB  = b_q;
        hi_d       = alu_out;
        state_d    = RD_LO;
      end
      RD_LO: begin
        alu_signal = FN_MFLO;
        alu_dataA  = a_q;
        alu_dataB  = b_q;
        lo_d       = alu_out;
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      err_q   <= err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign rsp_lo    = lo_q;
  assign rsp_hi    = hi_q;
  assign rsp_err   = err_q;

endmodule
